// File: rtl/alu_array_pkg.sv
// Shared types and constants for the backpressured lane ALU array.
package alu_array_pkg;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;

  localparam logic [8:0] ALU_OP_ADD = 9'h001;
  localparam logic [8:0] ALU_OP_SUB = 9'h002;
  localparam logic [8:0] ALU_OP_SEQ = 9'h003;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sew;
  } result_entry_t;

  // Broadcast the low element across the word so writeback sees every slot filled.
  function automatic logic [31:0] sew_replicate(input logic [31:0] data, input logic [1:0] sew);
    case (sew)
      SEW_8:   return {4{data[7:0]}};
      SEW_16:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count; flush empties it next cycle.
module alu_result_fifo
  import alu_array_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          push,
  input  result_entry_t wdata,
  input  logic          pop,
  output result_entry_t rdata,
  output logic [CW-1:0] count
);

  result_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;

  assign do_pop = pop & (count != '0);
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Credit accounting upstream should make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    (push && !flush) |-> (count != CW'(DEPTH)));

endmodule

// File: rtl/alu_submodule.sv
// Fixed-latency lane ALU: operands masked to input SEW, then ADD/SUB/SEQ/AND, optional accumulate of c.
module alu_submodule
  import alu_array_pkg::*;
#(
  parameter int OP_WIDTH    = 32,
  parameter int V_LANE_NUM  = 8,
  parameter int ALU_LATENCY = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [8:0]          alu_opmode_i,
  input  logic [OP_WIDTH-1:0] alu_a_i,
  input  logic [OP_WIDTH-1:0] alu_b_i,
  input  logic [OP_WIDTH-1:0] alu_c_i,
  input  logic [1:0]          input_sew_i,
  input  logic                alu_reduction_i,
  input  logic                alu_vld_i,
  output logic [OP_WIDTH-1:0] alu_o,
  output logic                alu_vld_o
);

  if (V_LANE_NUM < 1) begin : g_bad_lanes
    $error("alu_submodule: V_LANE_NUM must be >= 1");
  end

  logic [OP_WIDTH-1:0] msk, am, bm, cm, res;
  logic [ALU_LATENCY-1:0][OP_WIDTH-1:0] pd;
  logic [ALU_LATENCY-1:0]               pv;

  always_comb begin
    case (input_sew_i)
      SEW_8:   msk = OP_WIDTH'(8'hFF);
      SEW_16:  msk = OP_WIDTH'(16'hFFFF);
      default: msk = '1;
    endcase
    am = alu_a_i & msk;
    bm = alu_b_i & msk;
    cm = alu_c_i & msk;
    case (alu_opmode_i)
      ALU_OP_ADD: res = am + bm;
      ALU_OP_SUB: res = am - bm;
      ALU_OP_SEQ: res = OP_WIDTH'(am == bm);
      default:    res = am & bm;
    endcase
    if (alu_reduction_i) res = res + cm;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pd <= '0;
      pv <= '0;
    end else begin
      pd[0] <= res;
      pv[0] <= alu_vld_i;
      for (int j = 1; j < ALU_LATENCY; j++) begin
        pd[j] <= pd[j-1];
        pv[j] <= pv[j-1];
      end
    end
  end

  assign alu_o     = pd[ALU_LATENCY-1];
  assign alu_vld_o = pv[ALU_LATENCY-1];

endmodule

// File: rtl/alu_array_bp.sv
// Array of lane ALU channels with credit-throttled input, result FIFO, SEW replication and flush.
module alu_array_bp
  import alu_array_pkg::*;
#(
  parameter int OP_WIDTH        = 32,
  parameter int PARALLEL_IF_NUM = 4,
  parameter int V_LANE_NUM      = 8,
  parameter int ALU_LATENCY     = 3,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      flush_i,
  input  logic [PARALLEL_IF_NUM-1:0][8:0]           alu_opmode_i,
  input  logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0]  alu_a_i,
  input  logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0]  alu_b_i,
  input  logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0]  alu_c_i,
  input  logic [PARALLEL_IF_NUM-1:0][1:0]           input_sew_i,
  input  logic [PARALLEL_IF_NUM-1:0][1:0]           output_sew_i,
  input  logic [PARALLEL_IF_NUM-1:0]                alu_reduction_i,
  input  logic [PARALLEL_IF_NUM-1:0]                alu_vld_i,
  output logic [PARALLEL_IF_NUM-1:0]                alu_rdy_o,
  output logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0]  alu_o,
  output logic [PARALLEL_IF_NUM-1:0]                alu_mask_vector_o,
  output logic [PARALLEL_IF_NUM-1:0]                alu_vld_o,
  input  logic [PARALLEL_IF_NUM-1:0]                alu_rdy_i,
  output logic                                      idle_o
);

  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]    CREDITS = (CW+1)'(FIFO_DEPTH);

  if (OP_WIDTH != 32) begin : g_bad_width
    $error("alu_array_bp: result entries are 32 bits wide");
  end
  if (FIFO_DEPTH < ALU_LATENCY + 1) begin : g_bad_depth
    $error("alu_array_bp: FIFO_DEPTH must cover ALU_LATENCY+1");
  end

  logic [PARALLEL_IF_NUM-1:0] ch_idle;

  for (genvar i = 0; i < PARALLEL_IF_NUM; i++) begin : g_ch
    logic                          acc, push, pop, sub_vld;
    logic [OP_WIDTH-1:0]           sub_res;
    logic [ALU_LATENCY-1:0]        sr_vld;
    logic [ALU_LATENCY-1:0][1:0]   sr_sew;
    logic [CW-1:0]                 cnt, infl;
    result_entry_t                 wentry, head;

    // Credit covers both queued and in-flight results, so the FIFO can never overflow.
    assign alu_rdy_o[i] = (({1'b0, cnt} + {1'b0, infl}) < CREDITS) & ~flush_i;
    assign acc          = alu_vld_i[i] & alu_rdy_o[i];

    alu_submodule #(
      .OP_WIDTH    (OP_WIDTH),
      .V_LANE_NUM  (V_LANE_NUM),
      .ALU_LATENCY (ALU_LATENCY)
    ) u_alu (
      .clk             (clk),
      .rstn            (rstn),
      .alu_opmode_i    (alu_opmode_i[i]),
      .alu_a_i         (alu_a_i[i]),
      .alu_b_i         (alu_b_i[i]),
      .alu_c_i         (alu_c_i[i]),
      .input_sew_i     (input_sew_i[i]),
      .alu_reduction_i (alu_reduction_i[i]),
      .alu_vld_i       (acc),
      .alu_o           (sub_res),
      .alu_vld_o       (sub_vld)
    );

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sr_vld <= '0;
        sr_sew <= '0;
      end else if (flush_i) begin
        sr_vld <= '0;
        sr_sew <= '0;
      end else begin
        sr_vld[0] <= acc;
        sr_sew[0] <= output_sew_i[i];
        for (int j = 1; j < ALU_LATENCY; j++) begin
          sr_vld[j] <= sr_vld[j-1];
          sr_sew[j] <= sr_sew[j-1];
        end
      end
    end

    always_comb begin
      infl = '0;
      for (int j = 0; j < ALU_LATENCY; j++) infl = infl + CW'(sr_vld[j]);
    end

    assign push   = sr_vld[ALU_LATENCY-1];
    assign wentry = '{data: sub_res, sew: sr_sew[ALU_LATENCY-1]};
    assign pop    = alu_vld_o[i] & alu_rdy_i[i];

    alu_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush_i),
      .push  (push),
      .wdata (wentry),
      .pop   (pop),
      .rdata (head),
      .count (cnt)
    );

    assign alu_vld_o[i]         = (cnt != '0);
    assign alu_o[i]             = alu_vld_o[i] ? sew_replicate(head.data, head.sew) : '0;
    assign alu_mask_vector_o[i] = alu_vld_o[i] & head.data[0];
    assign ch_idle[i]           = (cnt == '0) && (sr_vld == '0);

    // Tracking is a subset of the submodule's own valid pipe (flush clears only ours).
    a_track: assert property (@(posedge clk) disable iff (!rstn) push |-> sub_vld);
  end

  assign idle_o = &ch_idle;

endmodule

// File: tb/tb_alu_array_bp.sv
// Randomized + directed bench for alu_array_bp against a queue-based per-channel model.
module tb_alu_array_bp;
  import alu_array_pkg::*;

  localparam int P = 4, W = 32, L = 3, D = 4;

  logic clk = 1'b0, rstn = 1'b0, flush = 1'b0;
  logic [P-1:0][8:0]   op;
  logic [P-1:0][W-1:0] a_v, b_v, c_v, dout;
  logic [P-1:0][1:0]   isew, osew;
  logic [P-1:0]        red, vin, rdy_o_w, mask, vout, rdy_in;
  logic                idle;

  always #5 clk = ~clk;

  alu_array_bp #(.OP_WIDTH(W), .PARALLEL_IF_NUM(P), .V_LANE_NUM(8),
                 .ALU_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .flush_i(flush),
    .alu_opmode_i(op), .alu_a_i(a_v), .alu_b_i(b_v), .alu_c_i(c_v),
    .input_sew_i(isew), .output_sew_i(osew), .alu_reduction_i(red),
    .alu_vld_i(vin), .alu_rdy_o(rdy_o_w), .alu_o(dout),
    .alu_mask_vector_o(mask), .alu_vld_o(vout), .alu_rdy_i(rdy_in), .idle_o(idle));

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sew;
    int          rc;   // first cycle the entry is visible at the output
  } ment_t;

  ment_t mq [P][$];
  int    cyc = 0;
  int    checks = 0, errors = 0;
  bit    cmp_en = 0;

  task automatic chk(input string nm, input int ch, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ch%0d got %h exp %h @%0t", nm, ch, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [8:0] o, input logic [31:0] a, b, c,
                                          input logic [1:0] s, input logic r);
    logic [31:0] m, x;
    m = (s == 2'b00) ? 32'hFF : (s == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (o == ALU_OP_ADD)      x = (a & m) + (b & m);
    else if (o == ALU_OP_SUB) x = (a & m) - (b & m);
    else if (o == ALU_OP_SEQ) x = ((a & m) == (b & m)) ? 32'd1 : 32'd0;
    else                      x = a & b & m;
    if (r) x = x + (c & m);
    return x;
  endfunction

  function automatic logic [31:0] rep(input logic [31:0] d, input logic [1:0] s);
    if (s == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (s == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  // Model: every accepted beat becomes visible L+1 cycles later, in order; credits = D minus unpopped beats.
  always @(posedge clk) begin
    int    sz;
    bit    vis;
    ment_t e;
    for (int c = 0; c < P; c++) begin
      if (!rstn || flush) mq[c].delete();
      else begin
        sz  = mq[c].size();
        vis = (sz > 0) && (mq[c][0].rc <= cyc);
        if (vin[c] && sz < D) begin
          e.data = ref_alu(op[c], a_v[c], b_v[c], c_v[c], isew[c], red[c]);
          e.sew  = osew[c];
          e.rc   = cyc + L + 1;
          mq[c].push_back(e);
        end
        if (vis && rdy_in[c]) void'(mq[c].pop_front());
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit          vis, all_empty;
    logic [31:0] ed;
    if (rstn && cmp_en) begin
      all_empty = 1;
      for (int c = 0; c < P; c++) begin
        vis = (mq[c].size() > 0) && (mq[c][0].rc <= cyc);
        if (mq[c].size() != 0) all_empty = 0;
        ed  = vis ? rep(mq[c][0].data, mq[c][0].sew) : 32'd0;
        chk("vld", c, 32'(vout[c]), 32'(vis));
        chk("rdy", c, 32'(rdy_o_w[c]), 32'((mq[c].size() < D) && !flush));
        chk("data", c, dout[c], ed);
        chk("mask", c, 32'(mask[c]), vis ? 32'(mq[c][0].data[0]) : 32'd0);
      end
      chk("idle", 0, 32'(idle), 32'(all_empty));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic one_beat(input int ch, input logic [31:0] av, bv, input logic [1:0] os,
                          output logic [31:0] d, output logic m, output int lat);
    tick();
    op[ch] = ALU_OP_ADD; a_v[ch] = av; b_v[ch] = bv; c_v[ch] = '0;
    isew[ch] = SEW_32; osew[ch] = os; red[ch] = 1'b0; vin[ch] = 1'b1;
    tick();
    vin[ch] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!vout[ch] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = dout[ch];
    m = mask[ch];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        m;
    int          lat, acc;
    logic [31:0] got[$];

    op = '0; a_v = '0; b_v = '0; c_v = '0; isew = '0; osew = '0;
    red = '0; vin = '0; rdy_in = '1;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    // 1: reset state
    @(negedge clk);
    chk("rst_rdy", 0, 32'(rdy_o_w), 32'hF);
    chk("rst_vld", 0, 32'(vout), 32'h0);
    chk("rst_idle", 0, 32'(idle), 32'h1);
    chk("rst_out", 0, dout[0] | dout[1] | dout[2] | dout[3], 32'h0);
    cmp_en = 1;

    // 2: basic add, latency, single beat
    one_beat(0, 32'd5, 32'd7, SEW_32, d, m, lat);
    chk("lat", 0, 32'(lat), 32'(L + 1));
    chk("add", 0, d, 32'h0000_000C);
    @(negedge clk);
    chk("one_beat", 0, 32'(vout[0]), 32'h0);
    chk("idle_back", 0, 32'(idle), 32'h1);

    // 3: output SEW replication
    one_beat(2, 32'h12, 32'h01, SEW_8, d, m, lat);
    chk("rep8", 2, d, 32'h1313_1313);
    chk("mask8", 2, 32'(m), 32'h1);
    one_beat(2, 32'h1234, 32'h1, SEW_16, d, m, lat);
    chk("rep16", 2, d, 32'h1235_1235);

    // 4: backpressure fills exactly D credits, then drains in order
    tick();
    rdy_in[1] = 1'b0; op[1] = ALU_OP_ADD; isew[1] = SEW_32; osew[1] = SEW_32;
    b_v[1] = '0; a_v[1] = 32'd1; vin[1] = 1'b1;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      bit took;
      @(negedge clk);
      took = rdy_o_w[1] && a_v[1] <= 32'd8;
      tick();
      if (took) begin
        acc++;
        a_v[1] = a_v[1] + 1;
      end
    end
    chk("credits", 1, 32'(acc), 32'(D));
    @(negedge clk);
    chk("rdy_full", 1, 32'(rdy_o_w[1]), 32'h0);
    tick();
    vin[1] = 1'b0; rdy_in[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (vout[1]) got.push_back(dout[1]);
    end
    chk("drain_n", 1, 32'(got.size()), 32'd4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("drain_ord", 1, got[k], 32'(k + 1));
    chk("rdy_back", 1, 32'(rdy_o_w[1]), 32'h1);

    // 5: flush discards in-flight beats
    tick();
    op[0] = ALU_OP_ADD; isew[0] = SEW_32; osew[0] = SEW_32;
    a_v[0] = 32'd3; b_v[0] = 32'd4; vin[0] = 1'b1;
    tick();
    a_v[0] = 32'd5;
    tick();
    vin[0] = 1'b0;
    for (int k = 0; k < L - 3; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", 0, 32'(idle), 32'h1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("flush_novld", 0, 32'(vout[0]), 32'h0);
    end
    one_beat(0, 32'd9, 32'd1, SEW_32, d, m, lat);
    chk("post_flush", 0, d, 32'd10);

    // 6: async reset with FIFO holding 2 and one in flight
    tick();
    rdy_in[3] = 1'b0; op[3] = ALU_OP_ADD; isew[3] = SEW_32; osew[3] = SEW_32;
    b_v[3] = '0; a_v[3] = 32'h100; vin[3] = 1'b1;
    tick(); a_v[3] = 32'h101;
    tick(); a_v[3] = 32'h102;
    tick(); vin[3] = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!vout[3] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("pre_rst_vld", 3, 32'(vout[3]), 32'h1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_vld", 0, 32'(vout), 32'h0);
    chk("async_out", 3, dout[3], 32'h0);
    chk("async_idle", 0, 32'(idle), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    rdy_in = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("no_stale", 3, 32'(vout), 32'h0);
    end

    // Random concurrent traffic with stalls and occasional flush
    for (int k = 0; k < 800; k++) begin
      tick();
      flush = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < P; c++) begin
        case ($urandom_range(0, 3))
          0: op[c] = ALU_OP_ADD;
          1: op[c] = ALU_OP_SUB;
          2: op[c] = ALU_OP_SEQ;
          default: op[c] = 9'($urandom);
        endcase
        a_v[c]    = $urandom;
        b_v[c]    = ($urandom_range(0, 3) == 0) ? a_v[c] : $urandom;
        c_v[c]    = $urandom;
        isew[c]   = 2'($urandom_range(0, 3));
        osew[c]   = 2'($urandom_range(0, 3));
        red[c]    = 1'($urandom_range(0, 1));
        vin[c]    = ($urandom_range(0, 1) == 1);
        rdy_in[c] = ($urandom_range(0, 4) < 3);
      end
    end
    tick();
    flush = 1'b0; vin = '0; rdy_in = '1;
    repeat (20) tick();
    @(negedge clk);
    chk("final_idle", 0, 32'(idle), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_array_bp.md
Name: alu_array_bp

Overview:
- Parametrised successor of the lane ALU wrapper.
- Instantiates PARALLEL_IF_NUM copies of alu_submodule through a generate loop.
- Adds per-channel valid/ready backpressure, credit-based input throttling, an output result FIFO, output-SEW replication, flush and an idle status.
- Sits between the lane operand-read stage and the lane writeback/mask unit, so writeback can stall without losing in-flight ALU results.

Parameters:
- OP_WIDTH, 32, operand/result width per channel.
- PARALLEL_IF_NUM, 4, number of independent ALU channels (1..8).
- V_LANE_NUM, 8, forwarded to alu_submodule.
- ALU_LATENCY, 3, fixed alu_submodule pipeline depth in cycles (>=1).
- FIFO_DEPTH, 4, per-channel result FIFO entries. Power of 2 and >= ALU_LATENCY+1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush of all channels.
- alu_opmode_i  in  [PARALLEL_IF_NUM][9]  DSP opmode per channel.
- alu_a_i, alu_b_i, alu_c_i  in  [PARALLEL_IF_NUM][OP_WIDTH]  operands.
- input_sew_i, output_sew_i  in  [PARALLEL_IF_NUM][2]  element width (00=8, 01=16, 10=32).
- alu_reduction_i  in  [PARALLEL_IF_NUM]  reduction op flag.
- alu_vld_i  in  [PARALLEL_IF_NUM]  operand valid.
- alu_rdy_o  out  [PARALLEL_IF_NUM]  channel can accept.
- alu_o  out  [PARALLEL_IF_NUM][OP_WIDTH]  result at FIFO head, SEW-replicated.
- alu_mask_vector_o  out  [PARALLEL_IF_NUM]  bit 0 of the unreplicated head result.
- alu_vld_o  out  [PARALLEL_IF_NUM]  result valid (FIFO not empty).
- alu_rdy_i  in  [PARALLEL_IF_NUM]  downstream accepts result.
- idle_o  out  1  all FIFOs empty and nothing in flight.

Behaviour:
- All channels are independent; any per-channel rule below applies per index i.
- Accept: a transfer happens when alu_vld_i[i] & alu_rdy_o[i]. Only accepted beats drive alu_submodule's alu_vld_i. Operands are passed unchanged.
- In-flight tracking:
  - Each channel keeps its own ALU_LATENCY-deep shift register of {valid, output_sew}, shifted every cycle.
  - The valid bit enters on accept.
  - The submodule's alu_vld_o is ignored.
- Credit:
  - alu_rdy_o[i] = ((fifo_count + inflight_count) < FIFO_DEPTH) & ~flush_i, computed from registered state.
  - A same-cycle pop does not free a credit until the next cycle (conservative). The FIFO therefore can never overflow; a push with the FIFO full is an assertion failure.
- Push: when the shift-register tail valid is 1, {raw result, output_sew} is written to the FIFO. Latency from accept to alu_vld_o=1 is ALU_LATENCY+1 cycles when the FIFO is empty.
- Pop:
  - The FIFO is first-word-fall-through.
  - alu_vld_o = count != 0.
  - Pop occurs on alu_vld_o & alu_rdy_i.
  - Push and pop in the same cycle leave count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Replication of the head result:
  - sew 00: byte 0 copied to all 4 bytes.
  - sew 01: halfword 0 copied to both halves.
  - sew 10: unchanged.
  - sew 11: unchanged.
- idle_o = AND over all channels of (count==0 & no in-flight valid).
- Flush (flush_i=1):
  - Next cycle: all FIFOs empty and all in-flight valid bits cleared. Results still emerging from the submodules are discarded.
  - alu_rdy_o=0 during the flush cycle, and inputs offered in that cycle are not accepted.
  - Flush has priority over a simultaneous push or pop.
- Reset (asynchronous, any time including mid-operation):
  - Counts, pointers and shift registers are 0.
  - alu_vld_o=0, alu_o=0, alu_mask_vector_o=0, idle_o=1, alu_rdy_o=all 1s after reset release.
  - FIFO storage need not be reset; the output mux forces 0 when empty.

Decomposition:
- Package alu_array_pkg holds:
  - SEW encodings (SEW_8, SEW_16, SEW_32).
  - The opmode constants used by tests (ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SEQ).
  - A result_entry_t struct {logic [31:0] data; logic [1:0] sew}.
  - A function sew_replicate(data, sew).
- Natural sub-module: alu_result_fifo (parametrised FWFT FIFO with count output), one per channel, generated alongside each alu_submodule.

Test Plan:
1. Reset release, no stimulus -> alu_rdy_o=all 1s, alu_vld_o=0, idle_o=1, alu_o=0.
2. Channel 0 ALU_OP_ADD, a=5, b=7, sew 10, alu_rdy_i=1 -> alu_o[0]=0x0000000C with alu_vld_o[0] exactly ALU_LATENCY+1 cycles after accept, one beat only, idle_o returns to 1.
3. Channel 2 ADD a=0x12, b=0x01, output_sew 00 -> alu_o[2]=0x13131313, alu_mask_vector_o[2]=1. Same with output_sew 01, a=0x1234, b=1 -> 0x12351235.
4. alu_rdy_i=0, alu_vld_i=1 held on channel 1 with incrementing a=1..8, b=0 -> exactly FIFO_DEPTH(4) beats accepted and alu_rdy_o[1] falls, no overflow. Releasing alu_rdy_i then yields 1,2,3,4 in order, after which alu_rdy_o[1] rises.
5. Two beats accepted, flush_i pulsed one cycle before the first result would push -> no alu_vld_o ever asserts for them, idle_o=1 the cycle after flush. The next beat a=9, b=1 returns 10.
6. rstn asserted while channel 3 FIFO holds 2 entries and 1 is in flight -> alu_vld_o drops immediately (asynchronous), no stale result after release, and all channels operate concurrently with random stall patterns matching a per-channel scoreboard.
